// File: rtl/pong_pkg.sv
// Pong game controller shared types.
// State encoding, pause codes and winner codes.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_OVER
  } state_t;

  localparam logic [1:0] PAUSE_PLAY = 2'b00;
  localparam logic [1:0] PAUSE_IDLE = 2'b01;
  localparam logic [1:0] PAUSE_HOLD = 2'b10;
  localparam logic [1:0] PAUSE_OVER = 2'b11;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

endpackage

// File: rtl/pong_btn_edge.sv
// Rising-edge detector for one debounced button.
// Pulse is high in the first cycle the level is seen high.
module pong_btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_rise
);

  logic r_prev;

  // Remember last cycle's button level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= i_btn;
  end

  assign o_rise = i_btn & ~r_prev;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game state controller: serve, play, point, game-over.
// Optional macro PONG_AUTO_RESTART_EN: OVER times out to IDLE.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 120,
  parameter int POINT_FRAMES = 60,
  parameter int OVER_FRAMES  = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       frame_tick,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic [5:0] score,
  output logic [1:0] pause,
  output logic       ball_rst,
  output logic       ball_en,
  output logic [1:0] winner
);

  localparam logic [2:0] LP_WIN        = 3'(WIN_SCORE);
  localparam logic [7:0] LP_SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] LP_POINT_LAST = 8'(POINT_FRAMES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [2:0] r_sl;
  logic [2:0] r_sr;
  logic [2:0] w_sl_nxt;
  logic [2:0] w_sr_nxt;
  logic [2:0] w_sl_inc;
  logic [2:0] w_sr_inc;
  logic [1:0] r_win;
  logic [1:0] w_win_nxt;
  logic       w_rise_l;
  logic       w_rise_r;
  logic       w_press;
  logic       w_over_to;

  pong_btn_edge u_edge_l (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_left),
    .o_rise (w_rise_l)
  );

  pong_btn_edge u_edge_r (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_right),
    .o_rise (w_rise_r)
  );

  assign w_press = w_rise_l | w_rise_r;

`ifdef PONG_AUTO_RESTART_EN
  localparam logic [7:0] LP_OVER_LAST = 8'(OVER_FRAMES - 1);
  assign w_over_to = frame_tick && (r_cnt == LP_OVER_LAST);
`else
  // No timeout; OVER_FRAMES is always >= 1, so this stays low.
  assign w_over_to = (OVER_FRAMES == 0);
`endif

  // Scores saturate at the winning value.
  assign w_sl_inc = (r_sl == LP_WIN) ? r_sl : r_sl + 3'd1;
  assign w_sr_inc = (r_sr == LP_WIN) ? r_sr : r_sr + 3'd1;

  // Next state, next score and next winner.
  always_comb begin
    w_state_nxt = r_state;
    w_sl_nxt    = r_sl;
    w_sr_nxt    = r_sr;
    w_win_nxt   = r_win;
    unique case (r_state)
      ST_IDLE: begin
        if (w_press) begin
          w_sl_nxt    = 3'd0;
          w_sr_nxt    = 3'd0;
          w_win_nxt   = WIN_NONE;
          w_state_nxt = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (frame_tick && r_cnt == LP_SERVE_LAST)
          w_state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        if (miss_left && miss_right) begin
          w_state_nxt = ST_POINT;
        end else if (miss_left) begin
          w_sr_nxt = w_sr_inc;
          if (w_sr_inc == LP_WIN) begin
            w_win_nxt   = WIN_RIGHT;
            w_state_nxt = ST_OVER;
          end else begin
            w_state_nxt = ST_POINT;
          end
        end else if (miss_right) begin
          w_sl_nxt = w_sl_inc;
          if (w_sl_inc == LP_WIN) begin
            w_win_nxt   = WIN_LEFT;
            w_state_nxt = ST_OVER;
          end else begin
            w_state_nxt = ST_POINT;
          end
        end
      end
      ST_POINT: begin
        if (frame_tick && r_cnt == LP_POINT_LAST)
          w_state_nxt = ST_SERVE;
      end
      ST_OVER: begin
        if (w_press || w_over_to)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, score and winner registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sl    <= 3'd0;
      r_sr    <= 3'd0;
      r_win   <= WIN_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_sl    <= w_sl_nxt;
      r_sr    <= w_sr_nxt;
      r_win   <= w_win_nxt;
    end
  end

  // Frame counter: clears on state entry, saturates at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= 8'd0;
    else if (w_state_nxt != r_state)
      r_cnt <= 8'd0;
    else if (frame_tick && r_cnt != 8'hFF)
      r_cnt <= r_cnt + 8'd1;
  end

  // Moore decode of status outputs from the state register.
  always_comb begin
    pause    = PAUSE_IDLE;
    ball_rst = 1'b1;
    ball_en  = 1'b0;
    unique case (r_state)
      ST_IDLE:  pause = PAUSE_IDLE;
      ST_SERVE: pause = PAUSE_HOLD;
      ST_PLAY: begin
        pause    = PAUSE_PLAY;
        ball_rst = 1'b0;
        ball_en  = 1'b1;
      end
      ST_POINT: pause = PAUSE_HOLD;
      ST_OVER:  pause = PAUSE_OVER;
      default:  pause = PAUSE_IDLE;
    endcase
  end

  assign score  = {r_sl, r_sr};
  assign winner = r_win;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl.
// Covers PONG_AUTO_RESTART_EN when the macro is defined.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_left;
  logic       btn_right;
  logic       frame_tick;
  logic       miss_left;
  logic       miss_right;
  logic [5:0] score;
  logic [1:0] pause;
  logic       ball_rst;
  logic       ball_en;
  logic [1:0] winner;

  int n_chk  = 0;
  int n_fail = 0;

  pong_game_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .frame_tick (frame_tick),
    .miss_left  (miss_left),
    .miss_right (miss_right),
    .score      (score),
    .pause      (pause),
    .ball_rst   (ball_rst),
    .ball_en    (ball_en),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse(input logic ml, input logic mr);
    miss_left  = ml;
    miss_right = mr;
    @(negedge clk);
    miss_left  = 1'b0;
    miss_right = 1'b0;
  endtask

  task automatic press(input logic bl, input logic br,
                       input logic tk);
    btn_left   = bl;
    btn_right  = br;
    frame_tick = tk;
    @(negedge clk);
    btn_left   = 1'b0;
    btn_right  = 1'b0;
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    btn_left   = 1'b0;
    btn_right  = 1'b0;
    frame_tick = 1'b0;
    miss_left  = 1'b0;
    miss_right = 1'b0;
    #2;
    check("rst_pause", 8'(pause), 8'h1);
    check("rst_score", 8'(score), 8'h0);
    check("rst_win", 8'(winner), 8'h0);
    check("rst_brst", 8'(ball_rst), 8'h1);
    check("rst_ben", 8'(ball_en), 8'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    press(1, 0, 0);
    check("serve_pause", 8'(pause), 8'h2);
    check("serve_ben", 8'(ball_en), 8'h0);
    ticks(119);
    check("serve_119", 8'(pause), 8'h2);
    ticks(1);
    check("play_pause", 8'(pause), 8'h0);
    check("play_ben", 8'(ball_en), 8'h1);
    check("play_brst", 8'(ball_rst), 8'h0);

    press(0, 1, 0);
    check("play_btn_ign", 8'(pause), 8'h0);

    pulse(0, 1);
    check("mr_score", 8'(score), 8'b001_000);
    check("mr_pause", 8'(pause), 8'h2);
    ticks(60);
    check("point_to_serve", 8'(pause), 8'h2);
    ticks(119);
    check("serve2_119", 8'(pause), 8'h2);
    ticks(1);
    check("play2", 8'(pause), 8'h0);

    pulse(1, 0);
    check("ml_score", 8'(score), 8'b001_001);
    pulse(1, 0);
    check("point_miss_ign", 8'(score), 8'b001_001);
    ticks(180);
    check("play3", 8'(pause), 8'h0);

    pulse(1, 1);
    check("both_score", 8'(score), 8'b001_001);
    check("both_pause", 8'(pause), 8'h2);
    ticks(180);

    for (int i = 0; i < 5; i++) begin
      pulse(0, 1);
      ticks(180);
    end
    check("l6_score", 8'(score), 8'b110_001);
    check("l6_play", 8'(pause), 8'h0);

    pulse(0, 1);
    check("lwin_score", 8'(score), 8'b111_001);
    check("lwin_win", 8'(winner), 8'h1);
    check("lwin_pause", 8'(pause), 8'h3);
    check("over_brst", 8'(ball_rst), 8'h1);
    check("over_ben", 8'(ball_en), 8'h0);
    pulse(1, 0);
    check("over_miss_ign", 8'(score), 8'b111_001);

`ifdef PONG_AUTO_RESTART_EN
    ticks(239);
    check("over_239", 8'(pause), 8'h3);
    ticks(1);
    check("auto_idle", 8'(pause), 8'h1);
`else
    ticks(250);
    check("over_hold", 8'(pause), 8'h3);
    press(1, 0, 0);
    check("over_to_idle", 8'(pause), 8'h1);
`endif
    check("idle_score", 8'(score), 8'b111_001);
    check("idle_win", 8'(winner), 8'h1);

    press(0, 1, 1);
    check("new_score", 8'(score), 8'h0);
    check("new_win", 8'(winner), 8'h0);
    ticks(119);
    check("entry_tick_119", 8'(pause), 8'h2);
    ticks(1);
    check("entry_tick_120", 8'(pause), 8'h0);

    for (int i = 0; i < 6; i++) begin
      pulse(1, 0);
      ticks(180);
    end
    pulse(1, 0);
    check("rwin_score", 8'(score), 8'b000_111);
    check("rwin_win", 8'(winner), 8'h2);
    check("rwin_pause", 8'(pause), 8'h3);

    press(0, 1, 0);
    check("over_idle2", 8'(pause), 8'h1);
    press(1, 0, 0);
    ticks(50);
    #1 reset = 1'b1;
    #1;
    check("async_pause", 8'(pause), 8'h1);
    check("async_score", 8'(score), 8'h0);
    check("async_win", 8'(winner), 8'h0);
    check("async_brst", 8'(ball_rst), 8'h1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    press(1, 0, 0);
    check("post_rst_press", 8'(pause), 8'h2);
    ticks(119);
    check("post_rst_119", 8'(pause), 8'h2);
    ticks(1);
    check("post_rst_play", 8'(pause), 8'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
